// File: rtl/heartbeat_tx.sv
// heartbeat_tx: a liveness beacon for the cell boundary.
// It sends framed copies of a free-running frame counter on one pin.
// Each frame is the sync pattern, then the counter MSB first, then an optional even-parity bit.
// The line code is Manchester or NRZ, and the half-bit period is set by a prescaler.
// The serial output can optionally pass through an inverter delay chain.

module inverter (
  input  logic a,
  output logic y
);

  assign y = ~a;

endmodule

module heartbeat_tx #(
  parameter int                   COUNT_WIDTH  = 8,
  parameter int                   SYNC_BITS    = 4,
  parameter logic [SYNC_BITS-1:0] SYNC_PATTERN = 4'b1110,
  parameter int                   PARITY_EN    = 1,
  parameter int                   DIV_WIDTH    = 8,
  parameter int                   CHAIN_LENGTH = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   mode,
  input  logic [DIV_WIDTH-1:0]   div,
  output logic                   signal,
  output logic                   frame_start,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   busy
);

  localparam int MAX_BITS   = (SYNC_BITS > COUNT_WIDTH) ? SYNC_BITS : COUNT_WIDTH;
  localparam int IDX_W      = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
  localparam int EXT_W      = 1 << IDX_W;
  localparam bit HAS_PARITY = (PARITY_EN != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    DATA   = 2'd2,
    PARITY = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
  logic                   phase_q, phase_d;
  logic [DIV_WIDTH-1:0]   prescale_q, prescale_d;
  logic [DIV_WIDTH-1:0]   div_lat_q, div_lat_d;
  logic                   mode_lat_q, mode_lat_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   frame_start_q, frame_start_d;

  logic [EXT_W-1:0]       sync_ext;
  logic [EXT_W-1:0]       count_ext;
  logic                   current_bit;
  logic                   line_level;
  logic                   half_done;
  logic                   end_of_frame;
  logic                   start_frame;

  // The sync pattern and counter are zero-extended so the bit index covers them exactly.
  assign sync_ext  = EXT_W'(SYNC_PATTERN);
  assign count_ext = EXT_W'(count_q);

  assign half_done    = (state_q != IDLE) && (prescale_q == div_lat_q);
  assign end_of_frame = half_done && phase_q && (bit_idx_q == '0) &&
                        ((state_q == PARITY) || ((state_q == DATA) && !HAS_PARITY));
  assign start_frame  = enable && ((state_q == IDLE) || end_of_frame);

  // Pick the frame bit currently on the wire from the registered state.
  always_comb begin
    current_bit = 1'b0;
    case (state_q)
      SYNC:    current_bit = sync_ext[bit_idx_q];
      DATA:    current_bit = count_ext[bit_idx_q];
      PARITY:  current_bit = ^count_q;
      default: current_bit = 1'b0;
    endcase
  end

  // Apply the line code latched for this frame: Manchester inverts the second half-bit.
  always_comb begin
    line_level = 1'b0;
    if (state_q != IDLE) begin
      line_level = mode_lat_q ? current_bit : (current_bit ^ phase_q);
    end
  end

  // Next-state logic: walk half-bits, then bits, then fields, and chain frames while enabled.
  always_comb begin
    state_d       = state_q;
    bit_idx_d     = bit_idx_q;
    phase_d       = phase_q;
    prescale_d    = prescale_q;
    div_lat_d     = div_lat_q;
    mode_lat_d    = mode_lat_q;
    count_d       = count_q;
    frame_start_d = 1'b0;

    if (state_q != IDLE) begin
      if (half_done) begin
        prescale_d = '0;
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (bit_idx_q != '0) begin
            bit_idx_d = bit_idx_q - IDX_W'(1);
          end else begin
            case (state_q)
              SYNC: begin
                state_d   = DATA;
                bit_idx_d = IDX_W'(COUNT_WIDTH - 1);
              end
              DATA: begin
                if (HAS_PARITY) begin
                  state_d = PARITY;
                end
              end
              default: begin
              end
            endcase
          end
        end
      end else begin
        prescale_d = prescale_q + DIV_WIDTH'(1);
      end
    end

    if (end_of_frame) begin
      count_d = count_q + COUNT_WIDTH'(1);
      state_d = IDLE;
    end

    if (start_frame) begin
      state_d       = SYNC;
      bit_idx_d     = IDX_W'(SYNC_BITS - 1);
      phase_d       = 1'b0;
      prescale_d    = '0;
      div_lat_d     = div;
      mode_lat_d    = mode;
      frame_start_d = 1'b1;
    end
  end

  // State register with synchronous reset; a reset mid-frame drops the partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      bit_idx_q     <= '0;
      phase_q       <= 1'b0;
      prescale_q    <= '0;
      div_lat_q     <= '0;
      mode_lat_q    <= 1'b0;
      count_q       <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_idx_q     <= bit_idx_d;
      phase_q       <= phase_d;
      prescale_q    <= prescale_d;
      div_lat_q     <= div_lat_d;
      mode_lat_q    <= mode_lat_d;
      count_q       <= count_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign frame_start = frame_start_q;
  assign count       = count_q;
  assign busy        = (state_q != IDLE);

  // Output delay chain. An odd-length chain gets one extra inversion so polarity is preserved.
  generate
`ifdef COCOTB_SIM
    assign signal = line_level;
`else
    if (CHAIN_LENGTH == 0) begin : g_bypass
      assign signal = line_level;
    end else begin : g_chain
      for (genvar i = 0; i < CHAIN_LENGTH; i++) begin : g_inv
        logic y_w;
        if (i == 0) begin : g_first
          inverter u_inv (.a(line_level), .y(y_w));
        end else begin : g_next
          inverter u_inv (.a(g_inv[i-1].y_w), .y(y_w));
        end
      end
      if ((CHAIN_LENGTH % 2) == 1) begin : g_fix
        assign signal = ~g_inv[CHAIN_LENGTH-1].y_w;
      end else begin : g_pass
        assign signal = g_inv[CHAIN_LENGTH-1].y_w;
      end
    end
`endif
  endgenerate

endmodule

// File: tb/tb_heartbeat_tx.sv
// Directed testbench for heartbeat_tx: it checks framing, the prescaler, NRZ, enable drop, reset and wrap.
// A second instance without parity and with an odd-length chain runs alongside on the same inputs.

module tb_heartbeat_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       mode;
  logic [7:0] div;

  logic       signal;
  logic       frameStart;
  logic [7:0] count;
  logic       busy;

  logic       npSignal;
  logic       npFrameStart;
  logic [7:0] npCount;
  logic       npBusy;

  int vectors     = 0;
  int miscompares = 0;

  logic [127:0] wave;
  logic [127:0] npWave;
  logic         fsFirst;
  logic [7:0]   countFirst;
  int           fsOthers;
  int           npFsIdx;
  int           busyLow;
  int           activity;

  heartbeat_tx dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .mode       (mode),
    .div        (div),
    .signal     (signal),
    .frame_start(frameStart),
    .count      (count),
    .busy       (busy)
  );

  heartbeat_tx #(
    .PARITY_EN   (0),
    .CHAIN_LENGTH(3)
  ) dutNoParity (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .mode       (mode),
    .div        (div),
    .signal     (npSignal),
    .frame_start(npFrameStart),
    .count      (npCount),
    .busy       (npBusy)
  );

  // Free-running clock; outputs are sampled and inputs driven on the falling edge
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic en, input logic m, input logic [7:0] d);
    rst    = r;
    enable = en;
    mode   = m;
    div    = d;
  endtask

  // Sample a fixed number of cycles, optionally changing div/enable after a given cycle
  task automatic captureFrame(input int cycles, input int midCycle, input logic [7:0] newDiv, input logic newEnable);
    wave     = '0;
    npWave   = '0;
    fsOthers = 0;
    npFsIdx  = -1;
    busyLow  = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      wave   = {wave[126:0], signal};
      npWave = {npWave[126:0], npSignal};
      if (i == 0) begin
        fsFirst    = frameStart;
        countFirst = count;
      end else if (frameStart) begin
        fsOthers++;
      end
      if (i > 0 && npFrameStart && npFsIdx < 0) npFsIdx = i;
      if (!busy) busyLow++;
      if (i == midCycle) begin
        div    = newDiv;
        enable = newEnable;
      end
    end
  endtask

  task automatic checkFrameStart(input string tag, input logic [7:0] expCount);
    checkOutput({tag, "_fs"}, fsFirst, 1'b1);
    checkOutput({tag, "_count"}, countFirst, expCount);
    checkOutput({tag, "_extra_fs"}, fsOthers, 0);
  endtask

  // Reference waveform of one frame, right-aligned, one entry per clock cycle
  function automatic logic [127:0] buildWave(input logic [7:0] cnt, input int hold, input logic nrz, input logic withParity);
    logic [12:0]  seq;
    logic [127:0] w;
    int           nbits;
    logic         b;
    logic         lvl;
    seq   = {4'b1110, cnt, ^cnt};
    nbits = withParity ? 13 : 12;
    w     = '0;
    for (int k = 0; k < nbits; k++) begin
      b = seq[12-k];
      for (int ph = 0; ph < 2; ph++) begin
        lvl = nrz ? b : ((ph == 0) ? b : ~b);
        for (int h = 0; h < hold; h++) w = {w[126:0], lvl};
      end
    end
    return w;
  endfunction

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    repeat (3) @(negedge clk);
    checkOutput("rst_signal", signal, 1'b0);
    checkOutput("rst_count", count, 8'd0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_fs", frameStart, 1'b0);
    checkOutput("rst_np_busy", npBusy, 1'b0);

    $display("[TB] basic Manchester framing, div=0");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
    captureFrame(26, -1, 8'd0, 1'b1);
    checkFrameStart("f0", 8'h00);
    checkOutput("f0_wave", wave, 26'b10101001_0101010101010101_01);
    checkOutput("f0_busy", busyLow, 0);
    checkOutput("np_fs_period", npFsIdx, 24);
    checkOutput("np_wave", npWave[25:2], 24'b10101001_0101010101010101);
    checkOutput("np_next_sync", npWave[1:0], 2'b10);

    $display("[TB] prescaler div=2, div changed mid-frame");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd2);
    captureFrame(78, 20, 8'd0, 1'b1);
    checkFrameStart("f1", 8'h01);
    checkOutput("f1_head", wave[77:72], 6'b111000);
    checkOutput("f1_wave", wave, buildWave(8'h01, 3, 1'b0, 1'b1));

    captureFrame(26, -1, 8'd0, 1'b1);
    checkFrameStart("f2", 8'h02);
    checkOutput("f2_wave", wave, buildWave(8'h02, 1, 1'b0, 1'b1));

    $display("[TB] enable dropped at cycle 10");
    captureFrame(26, 9, 8'd0, 1'b0);
    checkFrameStart("f3", 8'h03);
    checkOutput("f3_wave", wave, buildWave(8'h03, 1, 1'b0, 1'b1));
    checkOutput("f3_busy", busyLow, 0);
    activity = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) checkOutput("idle_count", count, 8'h04);
      if (signal || frameStart || busy) activity++;
    end
    checkOutput("idle_activity", activity, 0);

    $display("[TB] re-enable, then reset mid-frame");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
    captureFrame(12, -1, 8'd0, 1'b1);
    checkFrameStart("f4", 8'h04);
    checkOutput("f4_head", wave[11:0], 12'b10101001_0101);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
    @(negedge clk);
    checkOutput("midrst_signal", signal, 1'b0);
    checkOutput("midrst_count", count, 8'h00);
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_fs", frameStart, 1'b0);

    $display("[TB] NRZ frame after reset release");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd0);
    captureFrame(26, -1, 8'd0, 1'b1);
    checkFrameStart("nrz0", 8'h00);
    checkOutput("nrz0_wave", wave, 26'b11111100_0000000000000000_00);

    $display("[TB] parity and counter wrap");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
    captureFrame(26, -1, 8'd0, 1'b1);
    checkFrameStart("c01", 8'h01);
    checkOutput("c01_parity", wave[1:0], 2'b10);
    checkOutput("c01_wave", wave, buildWave(8'h01, 1, 1'b0, 1'b1));
    for (int k = 2; k <= 254; k++) begin
      captureFrame(26, -1, 8'd0, 1'b1);
    end
    captureFrame(26, -1, 8'd0, 1'b1);
    checkFrameStart("cff", 8'hFF);
    checkOutput("cff_parity", wave[1:0], 2'b01);
    checkOutput("cff_wave", wave, buildWave(8'hFF, 1, 1'b0, 1'b1));
    captureFrame(26, -1, 8'd0, 1'b1);
    checkFrameStart("wrap", 8'h00);
    checkOutput("wrap_wave", wave, buildWave(8'h00, 1, 1'b0, 1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
